// File: rtl/code_monitor_if.sv
// code_monitor_if: groups the code-tracking and counter-read signals of
// code_monitor. The master side drives code samples and read requests; the
// slave side (code_monitor) returns change/stability flags and read data.
interface code_monitor_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       code;
  logic             code_vld;
  logic             chg;
  logic             stable;
  logic [3:0]       sat;
  logic             rd_req;
  logic [1:0]       rd_sel;
  logic             rd_ack;
  logic [CNT_W-1:0] rd_data;

  modport master (
    output code, code_vld, rd_req, rd_sel,
    input  chg, stable, sat, rd_ack, rd_data
  );

  modport slave (
    input  code, code_vld, rd_req, rd_sel,
    output chg, stable, sat, rd_ack, rd_data
  );
endinterface

// File: rtl/code_monitor.sv
// code_monitor: watches the registered 2-bit code from the mux stage, pulses
// chg on a code change, raises stable once a code has been held for STABLE_N
// valid samples, and keeps one saturating occurrence counter per code value.
// Counters are read through a 4-phase rd_req/rd_ack handshake.
// Optional feature: define CODE_MON_CLR_ON_READ_EN to make a read clear the
// selected counter on its capture edge (an increment on that same edge is
// applied after the clear, so the counter ends at 1).
module code_monitor #(
  parameter int CNT_W    = 8,
  parameter int STABLE_N = 4
) (
  input logic           clk,
  input logic           rst_n,
  code_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [7:0]       RUN_TOP  = 8'(STABLE_N);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } rd_state_e;

  // Saturating +1: a counter at its maximum stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == CNT_MAX) begin
      return val;
    end else begin
      return val + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Registered state
  rd_state_e        state_r;
  logic [1:0]       prev_r;
  logic             have_prev_r;
  logic [7:0]       run_r;
  logic [CNT_W-1:0] cnt_r [4];
  logic             chg_r;
  logic             stable_r;
  logic [3:0]       sat_r;
  logic             rd_ack_r;
  logic [CNT_W-1:0] rd_data_r;

  // Next-state signals
  rd_state_e        state_nxt_s;
  logic             capture_s;
  logic [1:0]       prev_nxt_s;
  logic             have_prev_nxt_s;
  logic [7:0]       run_nxt_s;
  logic             chg_nxt_s;
  logic [3:0]       inc_s;
  logic [3:0]       clr_s;
  logic [CNT_W-1:0] cnt_nxt_s [4];
  logic [3:0]       sat_nxt_s;

  assign bus.chg     = chg_r;
  assign bus.stable  = stable_r;
  assign bus.sat     = sat_r;
  assign bus.rd_ack  = rd_ack_r;
  assign bus.rd_data = rd_data_r;

  // Code tracking: decide change pulse, run length, and which counter bumps.
  always_comb begin
    prev_nxt_s      = prev_r;
    have_prev_nxt_s = have_prev_r;
    run_nxt_s       = run_r;
    chg_nxt_s       = 1'b0;
    inc_s           = 4'b0000;
    if (bus.code_vld) begin
      if (!have_prev_r) begin
        prev_nxt_s       = bus.code;
        have_prev_nxt_s  = 1'b1;
        run_nxt_s        = 8'd1;
        inc_s[bus.code]  = 1'b1;
      end else if (bus.code == prev_r) begin
        if (run_r != RUN_TOP) begin
          run_nxt_s = run_r + 8'd1;
        end else begin
          run_nxt_s = run_r;
        end
      end else begin
        chg_nxt_s        = 1'b1;
        prev_nxt_s       = bus.code;
        run_nxt_s        = 8'd1;
        inc_s[bus.code]  = 1'b1;
      end
    end else begin
      prev_nxt_s      = prev_r;
      have_prev_nxt_s = have_prev_r;
      run_nxt_s       = run_r;
    end
  end

  // Read FSM: accept a request only from IDLE, release once rd_req drops.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.rd_req) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_ACK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!bus.rd_req) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Clear request for the counter being read (clear-on-read builds only).
  always_comb begin
    clr_s = 4'b0000;
`ifdef CODE_MON_CLR_ON_READ_EN
    if (capture_s) begin
      clr_s[bus.rd_sel] = 1'b1;
    end else begin
      clr_s = 4'b0000;
    end
`endif
  end

  // Counter update: clear first, then saturating increment; derive sat flags.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (clr_s[k]) begin
        cnt_nxt_s[k] = CNT_ZERO;
      end else begin
        cnt_nxt_s[k] = cnt_r[k];
      end
      if (inc_s[k]) begin
        cnt_nxt_s[k] = sat_inc(cnt_nxt_s[k]);
      end else begin
        cnt_nxt_s[k] = cnt_nxt_s[k];
      end
      sat_nxt_s[k] = (cnt_nxt_s[k] == CNT_MAX);
    end
  end

  // State and output registers; rd_data captures the pre-update counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      prev_r      <= 2'b00;
      have_prev_r <= 1'b0;
      run_r       <= 8'd0;
      chg_r       <= 1'b0;
      stable_r    <= 1'b0;
      sat_r       <= 4'b0000;
      rd_ack_r    <= 1'b0;
      rd_data_r   <= CNT_ZERO;
      for (int k = 0; k < 4; k++) begin
        cnt_r[k] <= CNT_ZERO;
      end
    end else begin
      state_r     <= state_nxt_s;
      prev_r      <= prev_nxt_s;
      have_prev_r <= have_prev_nxt_s;
      run_r       <= run_nxt_s;
      chg_r       <= chg_nxt_s;
      stable_r    <= (run_nxt_s == RUN_TOP);
      sat_r       <= sat_nxt_s;
      rd_ack_r    <= (state_nxt_s == ST_ACK);
      if (capture_s) begin
        rd_data_r <= cnt_r[bus.rd_sel];
      end else begin
        rd_data_r <= rd_data_r;
      end
      for (int k = 0; k < 4; k++) begin
        cnt_r[k] <= cnt_nxt_s[k];
      end
    end
  end

endmodule
